// File: rtl/div_hilo_unit_pkg.sv
// Shared types and constants for the HI/LO divide sequencer.
package div_hilo_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W        = 32;
    localparam int DEFAULT_SETTLE_CYCLES = 4;
    localparam int CNT_W                 = 4;

    // Wide enough for any DATA_W up to 64; the top slices what it needs.
    localparam logic [63:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/div_hilo_unit_if.sv
// CPU/divider-facing bus of the HI/LO divide sequencer.
interface div_hilo_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] div_a;
    logic [DATA_W-1:0] div_b;
    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] div_remainder;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    // CPU pipeline plus the divider it owns.
    modport master (
        output start, op_a, op_b, div_quotient, div_remainder,
               hi_we, lo_we, wr_data,
        input  div_a, div_b, busy, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op_a, op_b, div_quotient, div_remainder,
               hi_we, lo_we, wr_data,
        output div_a, div_b, busy, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/div_hilo_unit.sv
// Holds operands on the combinational divider for a fixed settle time,
// then captures quotient/remainder into LO/HI with a busy/done handshake.
module div_hilo_unit
    import div_hilo_unit_pkg::*;
#(
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic           clock,
    input  logic           clear_n,
    div_hilo_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] div_a_q;
    logic [DATA_W-1:0] div_b_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_a_q <= '0;
            div_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wr_data;
                    if (bus.lo_we) lo_q <= bus.wr_data;
                    if (bus.start) begin
                        if (bus.op_b != '0) begin
                            div_a_q <= bus.op_a;
                            div_b_q <= bus.op_b;
                            cnt     <= CNT_INIT;
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state   <= SETTLE;
                        end else begin
                            // Zero divisor resolves here and overrides any same-cycle write.
                            hi_q   <= bus.op_a;
                            lo_q   <= DIV_ZERO_LO[DATA_W-1:0];
                            dbz_q  <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    lo_q   <= bus.div_quotient;
                    hi_q   <= bus.div_remainder;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Directed bench for div_hilo_unit with a behavioural divider stub.
module tb_div_hilo_unit;

    localparam int DW = 32;
    localparam int SC = 4;

    logic clock   = 1'b0;
    logic clear_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    div_hilo_unit_if #(.DATA_W(DW)) bus ();

    div_hilo_unit #(.DATA_W(DW), .SETTLE_CYCLES(SC)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus.slave)
    );

    // Divider stub: 100/7 -> 14 r 2, 50/6 -> 8 r 2.
    assign bus.div_quotient  = (bus.div_b != '0) ? bus.div_a / bus.div_b : '0;
    assign bus.div_remainder = (bus.div_b != '0) ? bus.div_a % bus.div_b : '0;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a division and watches a 10-cycle window. inj_kind 1 = stray
    // start (9/3), 2 = lo_we of 0x1234, both applied in cycle inj_cyc.
    task automatic run_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int inj_cyc, input int inj_kind,
                           output int lat, output int busy_cnt,
                           output int done_cnt, output int errs);
        logic [DW-1:0] lo0;
        lo0 = bus.lo_out;
        lat = 0; busy_cnt = 0; done_cnt = 0; errs = 0;
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (bus.done) begin
                done_cnt++;
                if (lat == 0) lat = c;
            end
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.done) errs++;
            if (bus.div_a !== a || bus.div_b !== b) errs++;
            if (inj_kind == 2 && lat == 0 && bus.lo_out !== lo0) errs++;
            bus.start = 1'b0;
            bus.lo_we = 1'b0;
            if (c == inj_cyc && inj_kind == 1) begin
                bus.start = 1'b1; bus.op_a = 9; bus.op_b = 3;
            end
            if (c == inj_cyc && inj_kind == 2) begin
                bus.lo_we = 1'b1; bus.wr_data = 32'h1234;
            end
            tick();
        end
        bus.start = 1'b0; bus.lo_we = 1'b0;
    endtask

    initial begin
        int lat, bc, dc, er, n;
        bus.start = 0; bus.op_a = 0; bus.op_b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wr_data = 0;

        // Reset state
        #12;
        check("rst_busy", DW'(bus.busy), 0);
        check("rst_done", DW'(bus.done), 0);
        check("rst_dbz",  DW'(bus.div_by_zero), 0);
        check("rst_hi",   bus.hi_out, 0);
        check("rst_lo",   bus.lo_out, 0);
        check("rst_diva", bus.div_a, 0);
        tick();
        clear_n = 1'b1;
        tick();

        // Basic 100/7
        run_div(100, 7, 0, 0, lat, bc, dc, er);
        check("basic_lat",   DW'(lat), SC + 2);
        check("basic_busy",  DW'(bc), SC + 1);
        check("basic_ndone", DW'(dc), 1);
        check("basic_errs",  DW'(er), 0);
        check("basic_lo",    bus.lo_out, 14);
        check("basic_hi",    bus.hi_out, 2);
        check("basic_dbz",   DW'(bus.div_by_zero), 0);

        // Divide by zero
        bus.start = 1; bus.op_a = 32'h55; bus.op_b = 0;
        tick();
        bus.start = 0;
        check("dz_done", DW'(bus.done), 1);
        check("dz_busy", DW'(bus.busy), 0);
        check("dz_hi",   bus.hi_out, 32'h55);
        check("dz_lo",   bus.lo_out, 32'hFFFF_FFFF);
        check("dz_flag", DW'(bus.div_by_zero), 1);
        check("dz_diva", bus.div_a, 100);
        tick();
        check("dz_done_1cyc", DW'(bus.done), 0);
        check("dz_sticky",    DW'(bus.div_by_zero), 1);
        bus.start = 1; bus.op_a = 100; bus.op_b = 7;
        tick();
        bus.start = 0;
        check("dz_clear", DW'(bus.div_by_zero), 0);
        for (int i = 0; i < 8; i++) tick();

        // Start while busy is ignored
        run_div(100, 7, 2, 1, lat, bc, dc, er);
        check("sb_lat",   DW'(lat), SC + 2);
        check("sb_ndone", DW'(dc), 1);
        check("sb_errs",  DW'(er), 0);
        check("sb_lo",    bus.lo_out, 14);
        check("sb_hi",    bus.hi_out, 2);

        // Direct writes
        bus.hi_we = 1; bus.wr_data = 32'hDEADBEEF;
        tick();
        bus.hi_we = 0;
        check("mthi", bus.hi_out, 32'hDEADBEEF);
        check("mthi_lo_kept", bus.lo_out, 14);
        bus.hi_we = 1; bus.lo_we = 1; bus.wr_data = 32'hA5A5_0F0F;
        tick();
        bus.hi_we = 0; bus.lo_we = 0;
        check("both_hi", bus.hi_out, 32'hA5A5_0F0F);
        check("both_lo", bus.lo_out, 32'hA5A5_0F0F);
        run_div(100, 7, 3, 2, lat, bc, dc, er);
        check("lowe_busy_errs", DW'(er), 0);
        check("lowe_busy_lo",   bus.lo_out, 14);

        // Start + write together
        bus.start = 1; bus.op_a = 100; bus.op_b = 7;
        bus.hi_we = 1; bus.wr_data = 32'h111;
        tick();
        bus.start = 0; bus.hi_we = 0;
        check("sw_hi_e0", bus.hi_out, 32'h111);
        for (int i = 0; i < 8; i++) tick();
        check("sw_hi_cap", bus.hi_out, 2);
        bus.start = 1; bus.op_a = 32'h77; bus.op_b = 0;
        bus.lo_we = 1; bus.wr_data = 32'h222;
        tick();
        bus.start = 0; bus.lo_we = 0;
        check("swz_lo", bus.lo_out, 32'hFFFF_FFFF);
        check("swz_hi", bus.hi_out, 32'h77);
        tick();

        // Reset mid-division
        bus.start = 1; bus.op_a = 100; bus.op_b = 7;
        tick();
        bus.start = 0;
        tick();
        clear_n = 0;
        #1;
        check("mrst_busy", DW'(bus.busy), 0);
        check("mrst_done", DW'(bus.done), 0);
        check("mrst_hi",   bus.hi_out, 0);
        check("mrst_lo",   bus.lo_out, 0);
        check("mrst_dbz",  DW'(bus.div_by_zero), 0);
        clear_n = 1;
        tick();
        check("mrst_idle_busy", DW'(bus.busy), 0);
        check("mrst_no_cap",    bus.lo_out, 0);
        run_div(100, 7, 0, 0, lat, bc, dc, er);
        check("mrst_lat", DW'(lat), SC + 2);
        check("mrst_lo",  bus.lo_out, 14);

        // Back-to-back: second start in the done cycle
        bus.start = 1; bus.op_a = 100; bus.op_b = 7;
        tick();
        bus.start = 0;
        n = 0;
        while (!bus.done && n < 12) begin tick(); n++; end
        check("b2b_first_done", DW'(bus.done), 1);
        bus.start = 1; bus.op_a = 50; bus.op_b = 6;
        tick();
        bus.start = 0;
        check("b2b_accepted", DW'(bus.busy), 1);
        n = 1;
        while (!bus.done && n < 12) begin tick(); n++; end
        check("b2b_lat", DW'(n), SC + 2);
        check("b2b_lo",  bus.lo_out, 8);
        check("b2b_hi",  bus.hi_out, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_hilo_unit.md
Name: div_hilo_unit

Overview:
- Sequencer and result-register stage that sits directly downstream of the mini CPU's combinational 32-bit divider.
- Latches the operands and drives them, held stable, into the divider. Waits a fixed number of settle cycles for the deep ripple logic to resolve.
- Then captures quotient into LO and remainder into HI, which the CPU reads (mfhi/mflo) or writes directly (mthi/mtlo).
- Gives the pipeline a busy/done handshake and a divide-by-zero flag.

Parameters:
- DATA_W, 32, operand/result width; matches the divider.
- SETTLE_CYCLES, 4, full clock cycles the divider inputs are held before capture; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- start  in  1  request a division of op_a by op_b; sampled only in IDLE.
- op_a  in  DATA_W  dividend.
- op_b  in  DATA_W  divisor.
- div_a  out  DATA_W  dividend driven to the divider.
- div_b  out  DATA_W  divisor driven to the divider.
- div_quotient  in  DATA_W  quotient returned by the divider.
- div_remainder  in  DATA_W  remainder returned by the divider.
- hi_we  in  1  write wr_data into HI (mthi).
- lo_we  in  1  write wr_data into LO (mtlo).
- wr_data  in  DATA_W  direct-write data.
- busy  out  1  division in progress; the pipeline stalls mfhi/mflo/div.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_by_zero  out  1  sticky flag, set by a zero-divisor division.
- hi_out  out  DATA_W  HI register (remainder).
- lo_out  out  DATA_W  LO register (quotient).

Behaviour:
- Reset (clear_n low, asynchronous):
  - state=IDLE; all outputs, HI, LO and the counter go to 0.
  - Reset mid-division aborts it; no partial result is written.
- States are IDLE, SETTLE, CAPTURE.
- IDLE, start=1 and op_b!=0, at edge E0:
  - div_a<=op_a, div_b<=op_b, cnt<=SETTLE_CYCLES-1, div_by_zero<=0, busy<=1.
  - Next state is SETTLE.
- IDLE, start=1 and op_b==0, at edge E0:
  - No divider use and no SETTLE.
  - HI<=op_a, LO<=all ones, div_by_zero<=1, done<=1 in the cycle after E0; busy stays 0.
  - State stays IDLE.
- SETTLE:
  - Each edge decrements cnt.
  - At the edge where cnt==0, the next state is CAPTURE.
  - div_a/div_b stay constant throughout.
- CAPTURE, one edge:
  - LO<=div_quotient, HI<=div_remainder, done<=1, busy<=0.
  - Next state is IDLE.
- Latency and handshake:
  - For a non-zero divisor, done is high in the cycle after edge E0+SETTLE_CYCLES+1.
  - Total latency is SETTLE_CYCLES+2 cycles from start.
  - busy is high for exactly SETTLE_CYCLES+1 cycles.
  - busy and done are never high together.
- done is high for exactly one cycle; back-to-back start is accepted in the done cycle.
- div_a/div_b retain their last values in IDLE (no toggling into the divider).
- start while busy is ignored; no queueing.
- Direct writes:
  - hi_we/lo_we are honoured only in IDLE; while busy they are dropped.
  - hi_we and lo_we together both apply.
- Simultaneous start and write in IDLE:
  - Non-zero divisor: the write applies at E0, and the division overwrites HI/LO at capture.
  - Zero divisor: the divide-by-zero result takes precedence over the write.
- div_by_zero stays set until the next accepted start with a non-zero divisor, or reset.
- Arithmetic:
  - The block does no arithmetic. Results are passed through bit-exact at DATA_W.
  - Signedness and correction are the divider's responsibility.
- The counter is 4 bits wide.

Decomposition:
- Shared package holds:
  - State enum: IDLE=2'd0, SETTLE=2'd1, CAPTURE=2'd2.
  - DIV_ZERO_LO constant (all ones).
  - Default SETTLE_CYCLES.
- No sub-module is needed. The divider is instantiated alongside, at CPU level, and wired through div_a/div_b/div_quotient/div_remainder.

Test Plan:
- Bench uses a divider stub that returns 14/2 for 100/7. Stimulus: start, op_a=100, op_b=7, SETTLE_CYCLES=4. Required: busy high 5 cycles; done in cycle 6; LO=14, HI=2; div_a/div_b stable throughout.
- Divide by zero: op_a=0x55, op_b=0. Required: done in the next cycle, busy never set; HI=0x55, LO=0xFFFFFFFF, div_by_zero=1. A following 100/7 clears the flag.
- Start during busy: second start with op_a=9 in cycle 2. Required: ignored; result is still 14/2; only one done pulse.
- Direct writes: in IDLE, hi_we with wr_data=0xDEADBEEF gives hi_out=0xDEADBEEF next cycle. lo_we asserted while busy leaves LO unchanged until capture.
- Reset mid-operation: clear_n low during SETTLE. Required: immediately busy=0, done=0, HI=LO=0; state IDLE; a new start then completes normally.
- Back-to-back: start asserted in the done cycle. Required: accepted; second done exactly SETTLE_CYCLES+2 cycles later.
